// File: rtl/lsu_split_if.sv
// Request/response bus between a core and the lsu_split load/store unit.
// Valid/ready: a request transfers on a rising clock edge where i_req_valid and
// o_req_ready are both high; the requester holds all request fields stable until
// then. o_rsp_valid is a single-cycle pulse with o_rdata/o_misalign_err valid.
interface lsu_split_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_wren;
    logic [2:0]  i_func3;
    logic        o_rsp_valid;
    logic [31:0] o_rdata;
    logic        o_misalign_err;
    logic [1:0]  dbg_state;

    modport master (
        output i_req_valid, i_addr, i_wdata, i_wren, i_func3,
        input  o_req_ready, o_rsp_valid, o_rdata, o_misalign_err, dbg_state
    );

    modport slave (
        input  i_req_valid, i_addr, i_wdata, i_wren, i_func3,
        output o_req_ready, o_rsp_valid, o_rdata, o_misalign_err, dbg_state
    );
endinterface

// File: rtl/lsu_split.sv
// Load/store unit with synchronous DMEM, memory-mapped LED/HEX/LCD/switch IO and
// splitting of word-crossing DMEM accesses into two back-to-back word accesses.
module lsu_split #(
    parameter int DMEM_DEPTH  = 16384,
    parameter int NUM_HEX     = 8,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    lsu_split_if.slave           bus,
    input  logic [31:0]          i_io_sw,
    output logic [31:0]          o_io_ledr,
    output logic [31:0]          o_io_ledg,
    output logic [7*NUM_HEX-1:0] o_io_hex,
    output logic [31:0]          o_io_lcd
);
    localparam int AW = $clog2(DMEM_DEPTH);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state;
    logic        ready_q;
    logic        rsp_valid_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wren_q;
    logic [2:0]  func3_q;
    logic [31:0] ledr_q;
    logic [31:0] ledg_q;
    logic [31:0] lcd_q;
    logic [55:0] hex_q;
    logic [31:0] rd_q;
    logic [31:0] lo_q;
    logic [31:0] io_q;
    logic [31:0] mem [DMEM_DEPTH];

    logic [1:0]    off;
    logic          is_dmem;
    logic [19:0]   page;
    logic          is_ledr, is_ledg, is_hexl, is_hexh, is_lcd, is_sw;
    logic          crossing, bad_func, access_err, split;
    logic [3:0]    size_mask;
    logic [7:0]    lanes_wide;
    logic [63:0]   data_wide;
    logic [AW-1:0] idx0, idx1, mem_idx;
    logic [3:0]    mem_lanes;
    logic [31:0]   mem_data;
    logic          mem_we;
    logic [31:0]   io_rd;
    logic [31:0]   w0, sh, load_val;

    always_comb begin
        off      = addr_q[1:0];
        is_dmem  = ~addr_q[28];
        page     = addr_q[31:12];
        is_ledr  = ~is_dmem && page == 20'h10000;
        is_ledg  = ~is_dmem && page == 20'h10001;
        is_hexl  = ~is_dmem && page == 20'h10002;
        is_hexh  = ~is_dmem && page == 20'h10003;
        is_lcd   = ~is_dmem && page == 20'h10004;
        is_sw    = ~is_dmem && page == 20'h10010;
        crossing = (func3_q[1:0] == 2'd1 && off == 2'd3) ||
                   (func3_q[1:0] == 2'd2 && off != 2'd0);
        bad_func = wren_q ? (func3_q > 3'd2)
                          : (func3_q == 3'd3 || func3_q[2:1] == 2'b11);
        access_err = bad_func | (crossing & (~is_dmem | ~MISALIGN_EN));
        split      = crossing & is_dmem & MISALIGN_EN & ~bad_func;

        case (func3_q[1:0])
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        // Lanes/data past byte 3 belong to the following word of a split access.
        lanes_wide = {4'b0000, size_mask} << off;
        data_wide  = {32'd0, wdata_q} << {off, 3'b000};

        idx0      = addr_q[2 +: AW];
        idx1      = idx0 + AW'(1);
        mem_idx   = (state == ACC1) ? idx1 : idx0;
        mem_lanes = (state == ACC1) ? lanes_wide[7:4] : lanes_wide[3:0];
        mem_data  = (state == ACC1) ? data_wide[63:32] : data_wide[31:0];
        mem_we    = (state == ACC0 || state == ACC1) && wren_q && is_dmem && !access_err;
    end

    always_comb begin
        io_rd = 32'd0;
        if (is_ledr)      io_rd = ledr_q;
        else if (is_ledg) io_rd = ledg_q;
        else if (is_lcd)  io_rd = lcd_q;
        else if (is_hexl) io_rd = {1'b0, hex_q[27:21], 1'b0, hex_q[20:14],
                                   1'b0, hex_q[13:7],  1'b0, hex_q[6:0]};
        else if (is_hexh) io_rd = {1'b0, hex_q[55:49], 1'b0, hex_q[48:42],
                                   1'b0, hex_q[41:35], 1'b0, hex_q[34:28]};
        else if (is_sw)   io_rd = i_io_sw;
    end

    // Bytes above the access size are discarded by extension, so the second
    // word can feed the shifter even for unsplit accesses.
    always_comb begin
        w0 = is_dmem ? (split ? lo_q : rd_q) : io_q;
        case (off)
            2'd0:    sh = w0;
            2'd1:    sh = {rd_q[7:0],  w0[31:8]};
            2'd2:    sh = {rd_q[15:0], w0[31:16]};
            default: sh = {rd_q[23:0], w0[31:24]};
        endcase
        case (func3_q)
            3'd0:    load_val = {{24{sh[7]}}, sh[7:0]};
            3'd4:    load_val = {24'd0, sh[7:0]};
            3'd1:    load_val = {{16{sh[15]}}, sh[15:0]};
            3'd5:    load_val = {16'd0, sh[15:0]};
            default: load_val = sh;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_lanes[k]) mem[mem_idx][8*k +: 8] <= mem_data[8*k +: 8];
            end
        end
        rd_q <= mem[mem_idx];
        if (state == ACC1) lo_q <= rd_q;
        if (state == ACC0) io_q <= io_rd;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wren_q      <= 1'b0;
            func3_q     <= 3'd0;
            ledr_q      <= 32'd0;
            ledg_q      <= 32'd0;
            lcd_q       <= 32'd0;
            hex_q       <= 56'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        addr_q  <= bus.i_addr;
                        wdata_q <= bus.i_wdata;
                        wren_q  <= bus.i_wren;
                        func3_q <= bus.i_func3;
                        ready_q <= 1'b0;
                        state   <= ACC0;
                    end
                end
                ACC0: begin
                    if (wren_q && !access_err && !is_dmem) begin
                        for (int k = 0; k < 4; k++) begin
                            if (lanes_wide[k]) begin
                                if (is_ledr) ledr_q[8*k +: 8] <= data_wide[8*k +: 8];
                                if (is_ledg) ledg_q[8*k +: 8] <= data_wide[8*k +: 8];
                                if (is_lcd)  lcd_q[8*k +: 8]  <= data_wide[8*k +: 8];
                                if (is_hexl && k < NUM_HEX)
                                    hex_q[7*k +: 7] <= data_wide[8*k +: 7];
                                if (is_hexh && k + 4 < NUM_HEX)
                                    hex_q[7*(k+4) +: 7] <= data_wide[8*k +: 7];
                            end
                        end
                    end
                    state <= split ? ACC1 : RESP;
                end
                ACC1: state <= RESP;
                RESP: begin
                    rsp_valid_q <= 1'b1;
                    rdata_q     <= (access_err || wren_q) ? 32'd0 : load_val;
                    err_q       <= access_err;
                    ready_q     <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_req_ready    = ready_q;
    assign bus.o_rsp_valid    = rsp_valid_q;
    assign bus.o_rdata        = rdata_q;
    assign bus.o_misalign_err = err_q;
    assign bus.dbg_state      = state;
    assign o_io_ledr          = ledr_q;
    assign o_io_ledg          = ledg_q;
    assign o_io_lcd           = lcd_q;
    assign o_io_hex           = hex_q[7*NUM_HEX-1:0];
endmodule

// File: tb/tb_lsu_split.sv
// Directed bench for lsu_split: default instance, a MISALIGN_EN=0 instance and a
// NUM_HEX=4 instance, checked through an expected-response queue.
module tb_lsu_split;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_split_if bus0 ();
    lsu_split_if bus1 ();
    lsu_split_if bus2 ();

    logic [31:0]       sw;
    logic [2:0]        v, we;
    logic [2:0][31:0]  a, d;
    logic [2:0][2:0]   f3;
    logic [2:0]        rv, rdy, er;
    logic [2:0][31:0]  rd;
    logic [2:0][1:0]   st;
    logic [2:0][31:0]  ledr, ledg, lcd;
    logic [55:0]       hex0, hex1;
    logic [27:0]       hex2;

    assign bus0.i_req_valid = v[0];  assign bus0.i_addr = a[0];  assign bus0.i_wdata = d[0];
    assign bus0.i_wren = we[0];      assign bus0.i_func3 = f3[0];
    assign bus1.i_req_valid = v[1];  assign bus1.i_addr = a[1];  assign bus1.i_wdata = d[1];
    assign bus1.i_wren = we[1];      assign bus1.i_func3 = f3[1];
    assign bus2.i_req_valid = v[2];  assign bus2.i_addr = a[2];  assign bus2.i_wdata = d[2];
    assign bus2.i_wren = we[2];      assign bus2.i_func3 = f3[2];
    assign rv  = {bus2.o_rsp_valid, bus1.o_rsp_valid, bus0.o_rsp_valid};
    assign rdy = {bus2.o_req_ready, bus1.o_req_ready, bus0.o_req_ready};
    assign er  = {bus2.o_misalign_err, bus1.o_misalign_err, bus0.o_misalign_err};
    assign rd  = {bus2.o_rdata, bus1.o_rdata, bus0.o_rdata};
    assign st  = {bus2.dbg_state, bus1.dbg_state, bus0.dbg_state};

    lsu_split u_dut (
        .i_clk(clk), .i_reset(rst), .bus(bus0), .i_io_sw(sw),
        .o_io_ledr(ledr[0]), .o_io_ledg(ledg[0]), .o_io_hex(hex0), .o_io_lcd(lcd[0])
    );
    lsu_split #(.DMEM_DEPTH(16), .MISALIGN_EN(1'b0)) u_na (
        .i_clk(clk), .i_reset(rst), .bus(bus1), .i_io_sw(sw),
        .o_io_ledr(ledr[1]), .o_io_ledg(ledg[1]), .o_io_hex(hex1), .o_io_lcd(lcd[1])
    );
    lsu_split #(.DMEM_DEPTH(16), .NUM_HEX(4)) u_h4 (
        .i_clk(clk), .i_reset(rst), .bus(bus2), .i_io_sw(sw),
        .o_io_ledr(ledr[2]), .o_io_ledg(ledg[2]), .o_io_hex(hex2), .o_io_lcd(lcd[2])
    );

    int n_cmp;
    int n_fail;
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] ex);
        n_cmp++;
        assert (obs === ex) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, ex);
        end
    endtask

    task automatic xact(input int s, input logic [31:0] ad, input logic [31:0] wd,
                        input logic w, input logic [2:0] f, input logic [31:0] exp_data,
                        input logic exp_err, input int lat, input string tag);
        logic [32:0] exp;
        int n;
        bit got;
        exp_q.push_back({exp_err, exp_data});
        @(negedge clk);
        check({tag, "/ready"}, 64'(rdy[s]), 64'd1);
        v[s] = 1'b1; a[s] = ad; d[s] = wd; we[s] = w; f3[s] = f;
        @(posedge clk); #1;
        v[s] = 1'b0; a[s] = $urandom(); d[s] = $urandom();
        we[s] = 1'($urandom_range(0, 1)); f3[s] = 3'($urandom_range(0, 7));
        check({tag, "/busy"}, 64'(rdy[s]), 64'd0);
        n = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(posedge clk); #1;
            n++;
            got = rv[s];
        end
        check({tag, "/lat"}, 64'(got ? n : -1), 64'(lat));
        exp = exp_q.pop_front();
        check({tag, "/rsp"}, 64'({er[s], rd[s]}), 64'(exp));
        @(posedge clk); #1;
        check({tag, "/pulse"}, 64'(rv[s]), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [55:0] hexp;
        bit seen;
        n_cmp = 0; n_fail = 0;
        rst = 1'b0; v = '0; we = '0; a = '0; d = '0; f3 = '0; sw = 32'd0;
        #1 rst = 1'b1;
        #1;
        check("rst/ready", 64'(rdy[0]), 64'd1);
        check("rst/rsp_valid", 64'(rv[0]), 64'd0);
        check("rst/rdata", 64'(rd[0]), 64'd0);
        check("rst/err", 64'(er[0]), 64'd0);
        check("rst/ledr", 64'(ledr[0]), 64'd0);
        check("rst/hex", 64'(hex0), 64'd0);
        check("rst/state", 64'(st[0]), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Aligned word store/load
        xact(0, 32'h100, 32'h11223344, 1, 3'd2, 32'h0, 0, 2, "sw100");
        xact(0, 32'h100, 32'h0, 0, 3'd2, 32'h11223344, 0, 2, "lw100");
        xact(0, 32'h104, 32'h0, 1, 3'd2, 32'h0, 0, 2, "sw104");
        // Split store and split loads
        xact(0, 32'h102, 32'hAABBCCDD, 1, 3'd2, 32'h0, 0, 3, "sw102");
        xact(0, 32'h100, 32'h0, 0, 3'd2, 32'hCCDD3344, 0, 2, "lw100b");
        xact(0, 32'h104, 32'h0, 0, 3'd2, 32'h0000AABB, 0, 2, "lw104");
        xact(0, 32'h102, 32'h0, 0, 3'd2, 32'hAABBCCDD, 0, 3, "lw102");
        xact(0, 32'h103, 32'h0, 0, 3'd1, 32'hFFFFBBCC, 0, 3, "lh103");
        xact(0, 32'h103, 32'h0, 0, 3'd5, 32'h0000BBCC, 0, 3, "lhu103");
        // Byte store and sign/zero extension
        xact(0, 32'h200, 32'h0, 1, 3'd2, 32'h0, 0, 2, "sw200");
        xact(0, 32'h203, 32'h80, 1, 3'd0, 32'h0, 0, 2, "sb203");
        xact(0, 32'h203, 32'h0, 0, 3'd0, 32'hFFFFFF80, 0, 2, "lb203");
        xact(0, 32'h203, 32'h0, 0, 3'd4, 32'h00000080, 0, 2, "lbu203");
        xact(0, 32'h200, 32'h0, 0, 3'd2, 32'h80000000, 0, 2, "lw200");
        xact(0, 32'h202, 32'h0, 0, 3'd1, 32'hFFFF8000, 0, 2, "lh202");
        // Split across the last DMEM word wraps to word 0
        xact(0, 32'h0, 32'h55555555, 1, 3'd2, 32'h0, 0, 2, "sw0");
        xact(0, 32'hFFFC, 32'h0, 1, 3'd2, 32'h0, 0, 2, "swlast");
        xact(0, 32'hFFFE, 32'h12345678, 1, 3'd2, 32'h0, 0, 3, "swwrap");
        xact(0, 32'h0, 32'h0, 0, 3'd2, 32'h55551234, 0, 2, "lw0wrap");
        xact(0, 32'hFFFC, 32'h0, 0, 3'd2, 32'h56780000, 0, 2, "lwlast");
        xact(0, 32'hFFFE, 32'h0, 0, 3'd2, 32'h12345678, 0, 3, "lwwrap");
        // Illegal func3 and IO crossing give errors without writes
        xact(0, 32'h0, 32'h0, 0, 3'd3, 32'h0, 1, 2, "ld_f3");
        xact(0, 32'h0, 32'h0, 0, 3'd6, 32'h0, 1, 2, "ld_f6");
        xact(0, 32'h0, 32'hFFFFFFFF, 1, 3'd4, 32'h0, 1, 2, "st_f4");
        xact(0, 32'h0, 32'h0, 0, 3'd2, 32'h55551234, 0, 2, "lw0keep");
        xact(0, 32'h10000002, 32'h0, 0, 3'd2, 32'h0, 1, 2, "io_cross");
        // IO registers
        xact(0, 32'h10000000, 32'hDEADBEEF, 1, 3'd2, 32'h0, 0, 2, "ledr_sw");
        check("ledr", 64'(ledr[0]), 64'hDEADBEEF);
        xact(0, 32'h10001002, 32'h1234, 1, 3'd1, 32'h0, 0, 2, "ledg_sh");
        check("ledg", 64'(ledg[0]), 64'h12340000);
        xact(0, 32'h10004000, 32'hCAFEF00D, 1, 3'd2, 32'h0, 0, 2, "lcd_sw");
        check("lcd", 64'(lcd[0]), 64'hCAFEF00D);
        xact(0, 32'h10004000, 32'h0, 0, 3'd2, 32'hCAFEF00D, 0, 2, "lcd_lw");
        xact(0, 32'h10000003, 32'h0, 0, 3'd0, 32'hFFFFFFDE, 0, 2, "ledr_lb");
        xact(0, 32'h10002000, 32'h12, 1, 3'd0, 32'h0, 0, 2, "hex0_sb");
        xact(0, 32'h10003001, 32'h3F, 1, 3'd0, 32'h0, 0, 2, "hex5_sb");
        hexp = 56'h12;
        hexp[41:35] = 7'h3F;
        check("hex8", 64'(hex0), 64'(hexp));
        xact(0, 32'h10003000, 32'h0, 0, 3'd2, 32'h00003F00, 0, 2, "hexh_lw");
        xact(0, 32'h10002000, 32'h0, 0, 3'd2, 32'h00000012, 0, 2, "hexl_lw");
        sw = 32'h5;
        xact(0, 32'h10010000, 32'h0, 0, 3'd2, 32'h5, 0, 2, "sw_lw");
        sw = 32'h8001;
        xact(0, 32'h10010000, 32'h0, 0, 3'd1, 32'hFFFF8001, 0, 2, "sw_lh");
        xact(0, 32'h10010000, 32'h77, 1, 3'd2, 32'h0, 0, 2, "sw_store");
        xact(0, 32'h10020000, 32'h0, 0, 3'd2, 32'h0, 0, 2, "unmap_lw");
        xact(0, 32'h1000F000, 32'h99, 1, 3'd2, 32'h0, 0, 2, "unmap_sw");
        check("ledr_keep", 64'(ledr[0]), 64'hDEADBEEF);

        // MISALIGN_EN=0 instance
        xact(1, 32'h0, 32'h55555555, 1, 3'd2, 32'h0, 0, 2, "na_sw0");
        xact(1, 32'h3C, 32'h66666666, 1, 3'd2, 32'h0, 0, 2, "na_swlast");
        xact(1, 32'h3E, 32'h12345678, 1, 3'd2, 32'h0, 1, 2, "na_cross");
        xact(1, 32'h0, 32'h0, 0, 3'd2, 32'h55555555, 0, 2, "na_lw0");
        xact(1, 32'h3C, 32'h0, 0, 3'd2, 32'h66666666, 0, 2, "na_lwlast");
        xact(1, 32'h3, 32'h0, 0, 3'd1, 32'h0, 1, 2, "na_lh3");

        // NUM_HEX=4 instance ignores digits 4..7
        xact(2, 32'h10002000, 32'h12, 1, 3'd0, 32'h0, 0, 2, "h4_d0");
        xact(2, 32'h10003001, 32'h3F, 1, 3'd0, 32'h0, 0, 2, "h4_d5");
        check("h4_hex", 64'(hex2), 64'h12);
        xact(2, 32'h10003000, 32'h0, 0, 3'd2, 32'h0, 0, 2, "h4_hexh");
        xact(2, 32'h10002000, 32'h0, 0, 3'd2, 32'h12, 0, 2, "h4_hexl");

        // Reset during the second half of a split store
        xact(0, 32'h300, 32'h0, 1, 3'd2, 32'h0, 0, 2, "sw300");
        xact(0, 32'h304, 32'h0, 1, 3'd2, 32'h0, 0, 2, "sw304");
        @(negedge clk);
        v[0] = 1'b1; a[0] = 32'h302; d[0] = 32'h99887766; we[0] = 1'b1; f3[0] = 3'd2;
        @(posedge clk); #1;
        v[0] = 1'b0;
        @(posedge clk); #1;
        check("acc1/state", 64'(st[0]), 64'd2);
        rst = 1'b1;
        #1;
        check("mid/rsp_valid", 64'(rv[0]), 64'd0);
        check("mid/ready", 64'(rdy[0]), 64'd1);
        check("mid/state", 64'(st[0]), 64'd0);
        check("mid/rdata", 64'(rd[0]), 64'd0);
        check("mid/ledr", 64'(ledr[0]), 64'd0);
        check("mid/ledg", 64'(ledg[0]), 64'd0);
        check("mid/lcd", 64'(lcd[0]), 64'd0);
        check("mid/hex", 64'(hex0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rv[0]) seen = 1'b1;
        end
        check("mid/no_rsp", 64'(seen), 64'd0);
        check("mid/ready_after", 64'(rdy[0]), 64'd1);
        xact(0, 32'h300, 32'h0, 0, 3'd2, 32'h77660000, 0, 2, "lw300");
        xact(0, 32'h304, 32'h0, 0, 3'd2, 32'h0, 0, 2, "lw304");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
